pll_reset_seq: RTL and testbench

PLL_RESET_SEQ -- requirements
Module: pll_reset_seq

---
 rtl/pll_reset_seq.sv | 178 +++++++++++++++++
 tb/tb_pll_reset_seq.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_seq.sv
// ---------------------------------------------------------------------------
// pll_reset_seq
//
// Purpose:
//   Brings up a PLL from the free-running 50 MHz board clock. It pulses the
//   PLL reset, waits for lock with a timeout-and-retry loop, qualifies the
//   lock for a number of consecutive stable cycles, and only then releases
//   the downstream system reset. A later loss of lock puts the system back
//   into reset and records a sticky flag.
//
// Parameters:
//   SYNC_STAGES    - depth of the locked synchroniser (legal 2..4)
//   PLL_RST_CYCLES - cycles pll_rst is held high on every attempt
//   LOCK_TIMEOUT   - cycles allowed in WAIT_LOCK before a retry
//   STABLE_CYCLES  - consecutive synchronised-locked cycles before release
//
// Ports:
//   refclk    in   1  free-running board clock, every register runs on it
//   rst       in   1  synchronous active-high reset
//   locked    in   1  PLL lock indication, asynchronous to refclk
//   pll_rst   out  1  reset to the PLL
//   sys_rst   out  1  active-high reset for the PLL output clock domains;
//                     each consuming domain resynchronises it
//   ready     out  1  clocks valid and released
//   state     out  2  current state code (PLL_RST=0, WAIT_LOCK=1,
//                     STABLE=2, RUN=3)
//   retry_cnt out  4  number of lock timeouts, saturating at 15
//   lock_lost out  1  sticky: lock dropped while running
// ---------------------------------------------------------------------------
module pll_reset_seq #(
    parameter int SYNC_STAGES    = 2,
    parameter int PLL_RST_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 1024
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       locked,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [3:0] retry_cnt,
    output logic       lock_lost
);

    typedef enum logic [1:0] {
        ST_PLL_RST   = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_STABLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_t;

    // One shared counter serves all three timed states, so it is sized for
    // the longest of the three intervals.
    localparam int CNT_MAX_AB = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
    localparam int CNT_MAX    = (CNT_MAX_AB > PLL_RST_CYCLES) ? CNT_MAX_AB : PLL_RST_CYCLES;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);

    // The counter is cleared on entry to a state and counts one per edge
    // spent there, so "N cycles in the state" is the edge that sees N-1.
    localparam logic [CNT_W-1:0] PLL_RST_LAST = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    localparam logic [3:0] RETRY_MAX = 4'd15;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   locked_s;
    state_t                 state_q;
    state_t                 state_next;
    logic [CNT_W-1:0]       cnt;
    logic                   retry_bump;
    logic                   lock_drop;

    // Synchroniser for the asynchronous lock indication. Cleared by rst so
    // that a stale "locked" from before the reset cannot leak into the new
    // bring-up; the oldest stage is the only one the FSM ever looks at, so
    // the lock is seen exactly SYNC_STAGES edges after it changes.
    always_ff @(posedge refclk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Next-state decision. Besides the state to enter, it flags the two
    // side effects that belong to a particular transition: a lock timeout
    // (bumps the retry counter) and a lock loss while running (sets the
    // sticky flag). In WAIT_LOCK the lock test comes first so a lock that
    // arrives on the timeout cycle wins over the retry. PLL_RST deliberately
    // ignores locked_s: the PLL is being held in reset, so its lock output
    // means nothing until the pulse is complete.
    always_comb begin
        state_next = state_q;
        retry_bump = 1'b0;
        lock_drop  = 1'b0;
        case (state_q)
            ST_PLL_RST: begin
                if (cnt == PLL_RST_LAST) begin
                    state_next = ST_WAIT_LOCK;
                end
            end
            ST_WAIT_LOCK: begin
                if (locked_s) begin
                    state_next = ST_STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    state_next = ST_PLL_RST;
                    retry_bump = 1'b1;
                end
            end
            ST_STABLE: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                end else if (cnt == STABLE_LAST) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (!locked_s) begin
                    state_next = ST_WAIT_LOCK;
                    lock_drop  = 1'b1;
                end
            end
            default: begin
                state_next = ST_PLL_RST;
            end
        endcase
    end

    // Sequencer registers. The state, the shared counter and every output
    // are registered here. Outputs are decoded from the state being entered
    // rather than the current one, so they change on the very edge on which
    // the state changes: sys_rst drops and ready rises together with the
    // move into RUN, and sys_rst comes back on the edge that leaves RUN.
    // The counter restarts on any state change (which is what makes every
    // retry get a full PLL reset pulse and every re-qualification start from
    // scratch) and simply holds while running, where nothing is timed.
    // retry_cnt and lock_lost only ever grow; only rst brings them back.
    always_ff @(posedge refclk) begin
        if (rst) begin
            state_q   <= ST_PLL_RST;
            cnt       <= '0;
            pll_rst   <= 1'b1;
            sys_rst   <= 1'b1;
            ready     <= 1'b0;
            retry_cnt <= 4'd0;
            lock_lost <= 1'b0;
        end else begin
            state_q <= state_next;

            if (state_next != state_q) begin
                cnt <= '0;
            end else if (state_q != ST_RUN) begin
                cnt <= cnt + CNT_ONE;
            end

            pll_rst <= (state_next == ST_PLL_RST);
            sys_rst <= (state_next != ST_RUN);
            ready   <= (state_next == ST_RUN);

            if (retry_bump && (retry_cnt != RETRY_MAX)) begin
                retry_cnt <= retry_cnt + 4'd1;
            end

            if (lock_drop) begin
                lock_lost <= 1'b1;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_pll_reset_seq.sv
// ---------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Directed bench for pll_reset_seq with small parameters (SYNC_STAGES=2,
// PLL_RST_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8). The stimulus process
// drives rst/locked and, for every output change it should cause, queues
// the edge number and the full output vector it expects. A separate
// monitor samples the outputs on every falling edge; whenever the output
// vector changes it pops the next expectation and compares both the edge
// on which the change happened and the new values. Any change nobody
// expected, and any expectation still queued at the end, is an error.
// ---------------------------------------------------------------------------
module tb_pll_reset_seq;

    localparam int SYNC_STAGES    = 2;
    localparam int PLL_RST_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 32;
    localparam int STABLE_CYCLES  = 8;

    // One attempt = pll_rst pulse plus a full WAIT_LOCK timeout.
    localparam int ATTEMPT = PLL_RST_CYCLES + LOCK_TIMEOUT;

    typedef struct packed {
        logic [1:0] st;
        logic       pr;
        logic       sr;
        logic       rdy;
        logic [3:0] rc;
        logic       ll;
    } obs_t;

    typedef struct {
        int    cyc;
        obs_t  v;
        string name;
    } exp_t;

    logic       refclk;
    logic       rst;
    logic       locked;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic [1:0] state;
    logic [3:0] retry_cnt;
    logic       lock_lost;

    int   cyc;
    int   checks;
    int   errors;
    bit   mon_en;
    obs_t prev;
    exp_t exp_q[$];

    pll_reset_seq #(
        .SYNC_STAGES   (SYNC_STAGES),
        .PLL_RST_CYCLES(PLL_RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES)
    ) dut (
        .refclk   (refclk),
        .rst      (rst),
        .locked   (locked),
        .pll_rst  (pll_rst),
        .sys_rst  (sys_rst),
        .ready    (ready),
        .state    (state),
        .retry_cnt(retry_cnt),
        .lock_lost(lock_lost)
    );

    // 50 MHz board clock.
    initial begin
        refclk = 1'b0;
        forever #10 refclk = ~refclk;
    end

    // Rising-edge counter: after edge n has happened, cyc == n.
    always @(posedge refclk) begin
        cyc <= cyc + 1;
    end

    function automatic obs_t mk(input logic [1:0] st, input logic pr, input logic sr,
                                input logic rdy, input logic [3:0] rc, input logic ll);
        obs_t o;
        o.st  = st;
        o.pr  = pr;
        o.sr  = sr;
        o.rdy = rdy;
        o.rc  = rc;
        o.ll  = ll;
        return o;
    endfunction

    function automatic obs_t sample();
        return mk(state, pll_rst, sys_rst, ready, retry_cnt, lock_lost);
    endfunction

    task automatic checkOutput(input string name, input int act_cyc, input int exp_cyc,
                               input obs_t act, input obs_t exp_v);
        checks++;
        if ((act_cyc != exp_cyc) || (act !== exp_v)) begin
            errors++;
            $display("[TB] FAIL %s: got edge=%0d state=%0d pll_rst=%b sys_rst=%b ready=%b retry=%0d lost=%b, expected edge=%0d state=%0d pll_rst=%b sys_rst=%b ready=%b retry=%0d lost=%b",
                     name, act_cyc, act.st, act.pr, act.sr, act.rdy, act.rc, act.ll,
                     exp_cyc, exp_v.st, exp_v.pr, exp_v.sr, exp_v.rdy, exp_v.rc, exp_v.ll);
        end
    endtask

    task automatic expectChange(input string name, input int at_cyc, input obs_t v);
        exp_t e;
        e.cyc  = at_cyc;
        e.v    = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    // Inputs change 2 ns after the falling edge, so the monitor (which runs
    // on the falling edge itself) never races the stimulus.
    task automatic tick();
        @(negedge refclk);
        #2;
    endtask

    task automatic tickUntil(input int target);
        while (cyc < target) tick();
    endtask

    task automatic applyStimulus(input logic rst_v, input logic locked_v);
        rst    = rst_v;
        locked = locked_v;
    endtask

    // Monitor: compare on every change of the output vector.
    initial begin
        exp_t e;
        obs_t cur;
        forever begin
            @(negedge refclk);
            if (mon_en) begin
                cur = sample();
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("[TB] FAIL unexpected_change: edge=%0d state=%0d pll_rst=%b sys_rst=%b ready=%b retry=%0d lost=%b, expected no change",
                                 cyc, cur.st, cur.pr, cur.sr, cur.rdy, cur.rc, cur.ll);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput(e.name, cyc, e.cyc, cur, e.v);
                    end
                    prev = cur;
                end
            end
        end
    end

    obs_t RESET_OBS;

    initial begin
        int base;
        exp_t e;
        cyc       = 0;
        checks    = 0;
        errors    = 0;
        mon_en    = 1'b0;
        RESET_OBS = mk(2'd0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0);

        // Reset state.
        applyStimulus(1'b1, 1'b0);
        tickUntil(3);
        checkOutput("reset_state", cyc, 3, sample(), RESET_OBS);
        prev   = RESET_OBS;
        mon_en = 1'b1;

        // Nominal bring-up: locked sampled from edge 10 after release.
        base = cyc;
        applyStimulus(1'b0, 1'b0);
        expectChange("bringup_wait_lock", base + 4,  mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        expectChange("bringup_stable",    base + 12, mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        expectChange("bringup_run",       base + 20, mk(2'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0));
        tickUntil(base + 9);
        applyStimulus(1'b0, 1'b1);
        tickUntil(base + 24);

        // Lock loss in RUN, then re-lock.
        base = cyc;
        applyStimulus(1'b0, 1'b0);
        expectChange("lock_loss",      base + 3,  mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1));
        tickUntil(base + 5);
        applyStimulus(1'b0, 1'b1);
        expectChange("relock_stable",  base + 8,  mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b1));
        expectChange("relock_run",     base + 16, mk(2'd3, 1'b0, 0, 1'b1, 4'd0, 1'b1));
        tickUntil(base + 20);

        // One-cycle reset while running with lock_lost set; locked stays
        // high, so qualification starts right after the pll_rst pulse.
        // Then a 3-cycle glitch while the stable count is at 5.
        base = cyc;
        applyStimulus(1'b1, 1'b1);
        expectChange("mid_reset",        base + 1,  RESET_OBS);
        tick();
        applyStimulus(1'b0, 1'b1);
        expectChange("mid_reset_wait",   base + 5,  mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        expectChange("mid_reset_stable", base + 6,  mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        tickUntil(base + 9);
        applyStimulus(1'b0, 1'b0);
        expectChange("glitch_drop",      base + 12, mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        tickUntil(base + 12);
        applyStimulus(1'b0, 1'b1);
        expectChange("glitch_requal",    base + 15, mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        expectChange("glitch_run",       base + 23, mk(2'd3, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0));
        tickUntil(base + 26);

        // One timeout, then lock arriving exactly on the next timeout edge.
        base = cyc;
        applyStimulus(1'b1, 1'b0);
        expectChange("sim_reset",        base + 1,  RESET_OBS);
        tick();
        applyStimulus(1'b0, 1'b0);
        expectChange("sim_wait",         base + 5,  mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        expectChange("timeout_1",        base + 37, mk(2'd0, 1'b1, 1'b1, 1'b0, 4'd1, 1'b0));
        expectChange("timeout_1_wait",   base + 41, mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));
        tickUntil(base + 70);
        applyStimulus(1'b0, 1'b1);
        expectChange("lock_at_timeout",  base + 73, mk(2'd2, 1'b0, 1'b1, 1'b0, 4'd1, 1'b0));
        expectChange("lock_at_tmo_run",  base + 81, mk(2'd3, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0));
        tickUntil(base + 84);

        // Twenty timeouts in a row: retry_cnt climbs and saturates at 15.
        base = cyc;
        applyStimulus(1'b1, 1'b0);
        expectChange("sat_reset", base + 1, RESET_OBS);
        tick();
        applyStimulus(1'b0, 1'b0);
        expectChange("sat_wait_0", base + 5, mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0));
        for (int i = 1; i <= 20; i++) begin
            logic [3:0] rc;
            rc = (i > 15) ? 4'd15 : 4'(i);
            expectChange($sformatf("sat_timeout_%0d", i), base + 1 + ATTEMPT * i,
                         mk(2'd0, 1'b1, 1'b1, 1'b0, rc, 1'b0));
            expectChange($sformatf("sat_wait_%0d", i), base + 5 + ATTEMPT * i,
                         mk(2'd1, 1'b0, 1'b1, 1'b0, rc, 1'b0));
        end
        tickUntil(base + 5 + ATTEMPT * 20 + 4);
        checkOutput("retry_saturated", cyc, base + 5 + ATTEMPT * 20 + 4, sample(),
                    mk(2'd1, 1'b0, 1'b1, 1'b0, 4'd15, 1'b0));

        // Anything still queued never happened.
        tick();
        mon_en = 1'b0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("[TB] FAIL %s: got no output change, expected one at edge=%0d", e.name, e.cyc);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
